// File: rtl/prng_capture_display.sv
// prng_capture_display: debounced capture of the PRNG byte onto two seven-segment digits.
// LIVE follows rnd_in, a press arms capture on the next rnd_valid, HOLD freezes until the next press.
module prng_capture_display #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic       EN,
   input  logic [7:0] rnd_in,
   input  logic       rnd_valid,
   input  logic       btn_capture,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic       holding,
   output logic [7:0] captured,
   output logic [7:0] cap_count
);
   typedef enum logic [1:0] {LIVE = 2'd0, ARMED = 2'd1, HOLD = 2'd2} state_t;
   state_t      state_q, state_d;
   logic [1:0]  sync_q, sync_d;
   logic        deb_q, deb_d, holding_q, holding_d, press;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  disp_q, disp_d, cap_q, cap_d, num_q, num_d;

   function automatic logic [6:0] seg(input logic [3:0] n);
      case (n)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
   endfunction

   always_comb begin
      sync_d = {sync_q[0], btn_capture};
      deb_d = deb_q;
      cnt_d = 16'd0;
      if (sync_q[1] != deb_q) begin
         if (cnt_q == 16'(DEBOUNCE_CYCLES - 16'd1)) deb_d = ~deb_q;
         else cnt_d = cnt_q + 16'd1;
      end
      // press acts on the same edge that flips the debounced level
      press = deb_d & ~deb_q;
      state_d = state_q;
      disp_d = disp_q;
      cap_d = cap_q;
      num_d = num_q;
      case (state_q)
         LIVE: begin
            disp_d = rnd_valid ? rnd_in : disp_q;
            state_d = press ? ARMED : LIVE;
         end
         ARMED: begin
            if (rnd_valid) begin
               disp_d = rnd_in;
               cap_d = rnd_in;
               num_d = (num_q == 8'hFF) ? num_q : num_q + 8'd1;
               state_d = HOLD;
            end else if (press) state_d = LIVE;
         end
         HOLD: state_d = press ? LIVE : HOLD;
         default: state_d = LIVE;
      endcase
      holding_d = (state_d == HOLD);
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= LIVE;
         sync_q <= 2'b00;
         deb_q <= 1'b0;
         cnt_q <= 16'd0;
         disp_q <= 8'd0;
         cap_q <= 8'd0;
         num_q <= 8'd0;
         holding_q <= 1'b0;
      end else if (EN) begin
         state_q <= state_d;
         sync_q <= sync_d;
         deb_q <= deb_d;
         cnt_q <= cnt_d;
         disp_q <= disp_d;
         cap_q <= cap_d;
         num_q <= num_d;
         holding_q <= holding_d;
      end
   end

   assign hex0 = seg(disp_q[3:0]);
   assign hex1 = seg(disp_q[7:4]);
   assign holding = holding_q;
   assign captured = cap_q;
   assign cap_count = num_q;
endmodule

// File: doc/prng_capture_display.md
# prng_capture_display

Downstream display stage for the PRNG datapath. It takes the 8-bit muxed random byte and its update strobe, and debounces a capture push-button. It shows either the live random value or a frozen captured value on two seven-segment digits, and counts captures. It replaces the free-running decoder pair at the output of the top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16'd50_000: consecutive stable CLK cycles required before the debounced button level changes; legal range 1..65535.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- EN  input  1  enable; when low, all state is frozen (no counting, inputs ignored), outputs held.
- rnd_in  input  8  random byte from the PRNG mux.
- rnd_valid  input  1  one-cycle strobe, synchronous to CLK; rnd_in is new this cycle.
- btn_capture  input  1  raw, asynchronous, active-high push-button.
- hex0  output  7  low-nibble digit segments {g,f,e,d,c,b,a}, active-high.
- hex1  output  7  high-nibble digit segments, same encoding.
- holding  output  1  high in HOLD state.
- captured  output  8  last captured byte.
- cap_count  output  8  number of captures, saturating at 255.

## Operation
- Input conditioning: btn_capture passes through a 2-flop synchronizer. The debouncer then holds a level register `deb` and a 16-bit counter.
  - Counter resets to 0 whenever the synchronized input equals `deb`.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, `deb` flips and the counter clears.
  - press = one-cycle pulse on a `deb` 0->1 transition. Release generates nothing.
- State machine (2-bit), reset state LIVE:
  - LIVE: on rnd_valid, disp <= rnd_in. On press -> ARMED.
  - ARMED: on rnd_valid, disp <= rnd_in, captured <= rnd_in, cap_count <= min(cap_count+1, 255), -> HOLD. On press without rnd_valid -> LIVE (cancel). If press and rnd_valid occur together, the capture wins -> HOLD.
  - HOLD: disp frozen; rnd_valid ignored. On press -> LIVE.
  - Unused encoding -> LIVE on next edge.
- Press and rnd_valid in the same LIVE cycle: disp updates, state -> ARMED. No capture happens in that cycle; the capture uses the next rnd_valid.
- Display: hex0 = decode(disp[3:0]), hex1 = decode(disp[7:4]). Decode is combinational from the registered disp, with hex glyphs 0-F:
  - 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- holding = (state == HOLD), registered state decode.
- EN low: synchronizer, debouncer, FSM and registers are all held. Button activity during EN low is lost. Resuming EN continues from the frozen state.
- Reset values: disp=0 (hex0=hex1=7'h3F), captured=0, cap_count=0, holding=0, deb=0, debounce counter=0, synchronizer=0, state LIVE.

## Timing
- btn_capture rising -> press pulse: 2 sync cycles + DEBOUNCE_CYCLES stable cycles. A glitch shorter than DEBOUNCE_CYCLES produces no press.
- rnd_valid at edge N -> disp, hex0/hex1 (and captured, cap_count if ARMED) updated after edge N; visible in cycle N+1.
- press at edge N -> state/holding changes after edge N.
- reset asserted mid-operation: all outputs go to their reset values immediately, regardless of EN or CLK.
- cap_count at 255: further captures still latch captured; the count stays at 255.

## Test plan
- Reset with DEBOUNCE_CYCLES=4: assert reset mid-HOLD with cap_count=3 -> hex0=hex1=7'h3F, holding=0, cap_count=0, captured=0 without a clock edge.
- LIVE tracking: rnd_valid with rnd_in=8'hA5 -> next cycle hex1=7'h77, hex0=7'h6D; rnd_in=8'h3C without rnd_valid -> display unchanged.
- Capture: press (btn held ≥6 cycles), then rnd_valid with 8'h7E -> holding=1, captured=8'h7E, cap_count=1, hex1=7'h07, hex0=7'h79. Further rnd_valid with 8'h11 -> display unchanged. Second press -> holding=0.
- Debounce: btn high 3 cycles then low -> no state change. Btn high 6+ cycles -> exactly one press, even if held 1000 cycles.
- Simultaneous events: press pulse coincident with rnd_valid in LIVE -> ARMED, no capture, cap_count unchanged. Press coincident with rnd_valid in ARMED -> HOLD, capture taken.
- Saturation/EN: perform 257 captures -> cap_count=255 and captured equals the last byte. EN low while btn is pressed -> no press, state frozen; EN high -> operation resumes.
